// File: rtl/pipe_cla_adder_if.sv
// Operand/result bundle for pipe_cla_adder: an operand set travels with a
// valid/ready pair on the input side, a result with a valid/ready pair on the
// output side.
interface pipe_cla_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             SUB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Co;
  logic             OVF;
  logic             ZERO;

  // Producer of operands / consumer of results.
  modport master (
    output in_valid, A, B, Cin, SUB, out_ready,
    input  in_ready, out_valid, S, Co, OVF, ZERO
  );

  // The adder itself.
  modport slave (
    input  in_valid, A, B, Cin, SUB, out_ready,
    output in_ready, out_valid, S, Co, OVF, ZERO
  );
endinterface

// File: rtl/pipe_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor.
//
// The operands are split into NGRP groups of GROUP bits. Stage k holds a token
// whose groups 0..k-1 are already summed; stage k's logic resolves group k with
// a flat generate/propagate lookahead and hands the group carry-out to stage
// k+1. After the last group the result lands in an output register, so a
// result appears NGRP cycles after its operands were accepted.
//
// A single global stall (result waiting, consumer not ready) freezes every
// stage at once; bubbles move through the pipe like tokens but never raise
// out_valid.
module pipe_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input logic             clk,
  input logic             rst_n,
  pipe_cla_adder_if.slave bus
);

  localparam int NGRP = WIDTH / GROUP;
  localparam int LAST = NGRP - 1;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [GROUP-1:0] grp_t;

  // Pipeline stage registers. Stage k: operands, effective B, partial sum with
  // groups below k filled in, carry into group k, and the stage valid bit.
  logic [NGRP-1:0] v_q;
  word_t           a_q [NGRP];
  word_t           b_q [NGRP];
  word_t           s_q [NGRP];
  logic [NGRP-1:0] c_q;

  // Result register.
  logic  vout_q;
  word_t s_out_q;
  logic  co_q;
  logic  ovf_q;

  // Per-stage combinational results.
  word_t           s_nxt [NGRP];
  logic [NGRP-1:0] c_nxt;
  logic            ovf_nxt;

  logic stall;

  // Carries into every bit of one group plus the group carry-out. Each carry
  // is an independent sum of products of g, p and cin, so no carry depends on
  // another carry inside the group.
  function automatic logic [GROUP:0] cla_carries(input grp_t g, input grp_t p,
                                                 input logic cin);
    logic [GROUP:0] c;
    logic           term;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      term = cin;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  // A waiting result with no taker freezes the whole pipe.
  assign stall = vout_q & ~bus.out_ready;

  // Resolve group k in stage k and work out the signed overflow of the token
  // leaving the last stage.
  // NOTE: combinational blocks use blocking assignments and give every output
  // a default before any conditional path, so no latch can be inferred.
  always_comb begin
    grp_t           g;
    grp_t           p;
    logic [GROUP:0] c;
    g       = '0;
    p       = '0;
    c       = '0;
    c_nxt   = '0;
    ovf_nxt = 1'b0;
    for (int k = 0; k < NGRP; k++) begin
      g        = a_q[k][k*GROUP +: GROUP] & b_q[k][k*GROUP +: GROUP];
      p        = a_q[k][k*GROUP +: GROUP] ^ b_q[k][k*GROUP +: GROUP];
      c        = cla_carries(g, p, c_q[k]);
      s_nxt[k] = s_q[k];
      s_nxt[k][k*GROUP +: GROUP] = p ^ c[GROUP-1:0];
      c_nxt[k] = c[GROUP];
    end
    ovf_nxt = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &
              (s_nxt[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
  end

  // Valid bits and the result register: cleared by reset, frozen by stall.
  // The result register only reloads for a real token, so a trailing bubble
  // leaves the last result in place.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q     <= '0;
      vout_q  <= 1'b0;
      s_out_q <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (!stall) begin
      v_q[0] <= bus.in_valid;
      for (int k = 1; k < NGRP; k++) v_q[k] <= v_q[k-1];
      vout_q <= v_q[LAST];
      if (v_q[LAST]) begin
        s_out_q <= s_nxt[LAST];
        co_q    <= c_nxt[LAST];
        ovf_q   <= ovf_nxt;
      end
    end
  end

  // Operand/partial-sum datapath: load the effective operands at stage 0 and
  // shift tokens one stage per unstalled cycle.
  // NOTE: these registers deliberately have no reset; their contents matter
  // only under a set valid bit, and reset clears every valid bit.
  always_ff @(posedge clk) begin
    if (!stall) begin
      a_q[0] <= bus.A;
      b_q[0] <= bus.SUB ? ~bus.B : bus.B;
      c_q[0] <= bus.SUB | bus.Cin;
      s_q[0] <= '0;
      for (int k = 1; k < NGRP; k++) begin
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
        s_q[k] <= s_nxt[k-1];
        c_q[k] <= c_nxt[k-1];
      end
    end
  end

  assign bus.in_ready  = ~stall;
  assign bus.out_valid = vout_q;
  assign bus.S         = s_out_q;
  assign bus.Co        = co_q;
  assign bus.OVF       = ovf_q;
  assign bus.ZERO      = ~|s_out_q;

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Bench for pipe_cla_adder: a 16/4 and a 32/8 instance driven with the same
// handshake, checked against an arithmetic model through per-instance
// scoreboards, plus directed vectors with literal expectations.
module tb_pipe_cla_adder;

  localparam int W1  = 16;
  localparam int G1  = 4;
  localparam int W2  = 32;
  localparam int G2  = 8;
  localparam int LAT = 4;

  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ovf;
    logic        zero;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pipe_cla_adder_if #(.WIDTH(W1)) i1 ();
  pipe_cla_adder_if #(.WIDTH(W2)) i2 ();

  pipe_cla_adder #(.WIDTH(W1), .GROUP(G1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
  pipe_cla_adder #(.WIDTH(W2), .GROUP(G2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(i2.slave));

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t q [2][$];
  int   n_acc  [2] = '{0, 0};
  int   n_done [2] = '{0, 0};
  logic prev_stall [2] = '{1'b0, 1'b0};
  res_t held [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain modular arithmetic on a w-bit word.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub, input int w);
    logic [63:0] mask;
    logic [63:0] bb;
    logic [63:0] aa;
    logic [63:0] full;
    res_t        r;
    mask   = (64'd1 << w) - 64'd1;
    aa     = {32'd0, a} & mask;
    bb     = sub ? (~{32'd0, b}) & mask : {32'd0, b} & mask;
    full   = aa + bb + (sub ? 64'd1 : {63'd0, cin});
    r.s    = full[31:0] & mask[31:0];
    r.co   = full[w];
    r.ovf  = (aa[w-1] == bb[w-1]) && (r.s[w-1] != aa[w-1]);
    r.zero = (r.s == 32'd0);
    return r;
  endfunction

  // Per-instance scoreboard step, evaluated at the falling edge for the
  // handshakes that will complete on the next rising edge.
  task automatic mon(input int id, input int w, input logic iv, input logic ir,
                     input logic ov, input logic orr, input logic [31:0] a,
                     input logic [31:0] b, input logic cin, input logic sub,
                     input res_t got);
    res_t exp;
    check($sformatf("dut%0d in_ready", id), {63'd0, ir}, {63'd0, !(ov && !orr)});
    if (prev_stall[id]) begin
      check($sformatf("dut%0d hold", id), {28'd0, ov, got}, {28'd0, 1'b1, held[id]});
    end
    if (iv && ir) begin
      q[id].push_back(model(a, b, cin, sub, w));
      n_acc[id]++;
    end
    if (ov && orr) begin
      n_done[id]++;
      if (q[id].size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut%0d result: got S=0x%0h with nothing outstanding, required no out_valid",
                 id, got.s);
      end else begin
        exp = q[id].pop_front();
        check($sformatf("dut%0d result", id), {29'd0, got}, {29'd0, exp});
      end
    end
    prev_stall[id] = ov && !orr;
    held[id]       = got;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        n_acc[i] -= q[i].size();
        q[i].delete();
        prev_stall[i] = 1'b0;
      end
    end else begin
      mon(0, W1, i1.in_valid, i1.in_ready, i1.out_valid, i1.out_ready,
          {16'd0, i1.A}, {16'd0, i1.B}, i1.Cin, i1.SUB,
          '{s: {16'd0, i1.S}, co: i1.Co, ovf: i1.OVF, zero: i1.ZERO});
      mon(1, W2, i2.in_valid, i2.in_ready, i2.out_valid, i2.out_ready,
          i2.A, i2.B, i2.Cin, i2.SUB,
          '{s: i2.S, co: i2.Co, ovf: i2.OVF, zero: i2.ZERO});
    end
  end

  task automatic set_ops(input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub);
    i1.A = a[15:0]; i1.B = b[15:0]; i1.Cin = cin; i1.SUB = sub;
    i2.A = a;       i2.B = b;       i2.Cin = cin; i2.SUB = sub;
  endtask

  task automatic set_hs(input logic iv, input logic orr);
    i1.in_valid = iv; i1.out_ready = orr;
    i2.in_valid = iv; i2.out_ready = orr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated operation on an empty pipe: checks latency and the 16-bit
  // result against hand-computed literals.
  task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub, input logic [15:0] es,
                         input logic eco, input logic eovf, input logic ez);
    int n;
    set_ops(a, b, cin, sub);
    set_hs(1'b1, 1'b1);
    tick();
    set_hs(1'b0, 1'b1);
    n = 0;
    while (!i1.out_valid && n < 20) begin
      tick();
      n++;
    end
    check({name, " latency"}, 64'(n), 64'(LAT));
    check(name, {45'd0, i1.S, i1.Co, i1.OVF, i1.ZERO}, {45'd0, es, eco, eovf, ez});
    tick();
  endtask

  task automatic drain();
    int n;
    set_hs(1'b0, 1'b1);
    n = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && n < 50) begin
      tick();
      n++;
    end
    tick();
    check("drain outstanding", 64'(q[0].size() + q[1].size()), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sa [8];
    logic [31:0] sb [8];
    logic [3:0]  pat;
    int          sent;
    int          cyc;
    int          acc;
    int          base;
    logic [31:0] ra;
    logic [31:0] rb;

    set_ops('0, '0, 1'b0, 1'b0);
    set_hs(1'b0, 1'b1);

    // Model pins.
    check("model pin carry", {29'd0, model(32'h0000FFFF, 32'h1, 1'b0, 1'b0, W1)},
          {29'd0, 32'h0, 1'b1, 1'b0, 1'b1});
    check("model pin sub", {29'd0, model(32'h8000, 32'h1, 1'b0, 1'b1, W1)},
          {29'd0, 32'h7FFF, 1'b1, 1'b1, 1'b0});

    // Reset state.
    repeat (3) tick();
    check("reset dut0", {45'd0, i1.out_valid, i1.in_ready, i1.S, i1.Co, i1.OVF, i1.ZERO},
          {45'd0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b1});
    check("reset dut1", {29'd0, i2.out_valid, i2.in_ready, i2.S, i2.Co, i2.OVF, i2.ZERO},
          {29'd0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1});
    rst_n = 1'b1;

    // Directed vectors (first one is accepted on the first edge after release).
    run_one("add 0+1",         32'h0000, 32'h0001, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_one("add ffff+1",      32'hFFFF, 32'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_one("add 7fff+1",      32'h7FFF, 32'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_one("sub 5-7",         32'h0005, 32'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_one("sub 8000-1",      32'h8000, 32'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_one("add cin",         32'h1234, 32'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0);
    run_one("sub equal",       32'h1234, 32'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_one("add neg ovf",     32'h8000, 32'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);

    // Back-to-back stream under a 1,0,0,1 out_ready pattern.
    sa  = '{32'h0001, 32'hFFFF, 32'h7FFF, 32'h8000, 32'h00F0, 32'h1234, 32'hAAAA, 32'h0000};
    sb  = '{32'h0002, 32'h0001, 32'h7FFF, 32'h0001, 32'h0F0F, 32'h1234, 32'h5555, 32'h0001};
    pat = 4'b1001;
    base = n_done[0];
    sent = 0;
    cyc  = 0;
    while (sent < 8 && cyc < 200) begin
      set_ops(sa[sent], sb[sent], sent[0], sent[1]);
      set_hs(1'b1, pat[cyc % 4]);
      @(negedge clk);
      if (i1.in_ready) sent++;
      tick();
      cyc++;
    end
    check("stream accepted", 64'(sent), 64'd8);
    drain();
    check("stream results", 64'(n_done[0] - base), 64'd8);

    // Reset with three tokens in flight.
    for (int i = 0; i < 3; i++) begin
      set_ops(32'h100 * i, 32'h11, 1'b0, 1'b0);
      set_hs(1'b1, 1'b1);
      tick();
    end
    set_hs(1'b0, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("flushed out_valid", {63'd0, i1.out_valid | i2.out_valid}, 64'd0);
      tick();
    end
    run_one("after flush",     32'h0003, 32'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0);

    // Random traffic on both widths with random back-pressure.
    acc = 0;
    cyc = 0;
    while (acc < 10000 && cyc < 60000) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFFF;
      if ($urandom_range(0, 7) == 0) rb = ~ra;
      set_ops(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      set_hs($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0);
      @(negedge clk);
      if (i1.in_valid && i1.in_ready) acc++;
      tick();
      cyc++;
    end
    check("random accepted", 64'(acc), 64'd10000);
    drain();
    check("dut0 done vs accepted", 64'(n_done[0]), 64'(n_acc[0]));
    check("dut1 done vs accepted", 64'(n_done[1]), 64'(n_acc[1]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_cla_adder.md
PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width in bits; legal values are multiples of GROUP, minimum GROUP.
REQ-002 SHALL have parameter GROUP, default 4, carry-lookahead group width in bits; NGRP = WIDTH/GROUP; pipeline depth is NGRP stages.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous assertion, active-low.
REQ-005 SHALL have port in_valid, input, 1, operand set presented.
REQ-006 SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-007 SHALL have port A, input, WIDTH, operand A.
REQ-008 SHALL have port B, input, WIDTH, operand B.
REQ-009 SHALL have port Cin, input, 1, carry-in; used only when SUB=0.
REQ-010 SHALL have port SUB, input, 1, mode select: 0 = add, 1 = subtract.
REQ-011 SHALL have port out_valid, output, 1, result present on S/Co/OVF/ZERO.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-013 SHALL have port S, output, WIDTH, sum/difference.
REQ-014 SHALL have port Co, output, 1, carry-out of the MSB group (SUB=1: 1 = no borrow).
REQ-015 SHALL have port OVF, output, 1, two's-complement signed overflow.
REQ-016 SHALL have port ZERO, output, 1, S equals zero.

Function
REQ-017 SHALL compute S,Co = A + B + Cin when SUB=0, and A + ~B + 1 when SUB=1 (Cin ignored); all arithmetic modulo 2^WIDTH, Co is bit WIDTH.
REQ-018 SHALL use, within each group, generate/propagate lookahead (G=A&B, P=A^B, carries from G/P and group carry-in); no ripple chain across a group.
REQ-019 SHALL resolve group k (LSB group k=0) in pipeline stage k; the group carry-out registers into stage k+1; unprocessed upper operand bits and already-produced lower sum bits travel with the token.
REQ-020 SHALL register A, B (inverted if SUB), effective carry-in and a valid bit at stage 0 on acceptance, i.e. in_valid & in_ready.
REQ-021 SHALL present the result NGRP cycles after acceptance when no stall occurs; throughput one operation per cycle.
REQ-022 SHALL drive OVF = (MSB of A == MSB of effective B) & (MSB of S != MSB of A), with effective B = ~B under SUB.
REQ-023 SHALL drive ZERO combinationally from the final-stage S.
REQ-024 SHALL define stall = out_valid & ~out_ready; while stall, every pipeline register including valid bits holds, and in_ready = 0.
REQ-025 SHALL drive in_ready = ~stall; bubbles (valid=0) advance like tokens and never appear as out_valid.
REQ-026 SHALL complete a result on the cycle with out_valid & out_ready; if a new token is in the previous stage it appears the following cycle (no lost or duplicated results).
REQ-027 SHALL hold S/Co/OVF/ZERO stable while out_valid=1 and out_ready=0.
REQ-028 SHALL keep operand values of non-valid stages don't-care but drive outputs from registers only.
REQ-029 SHALL preserve operation order; each result pairs with exactly one accepted operand set.

Reset
REQ-030 SHALL, while rst_n=0, clear all valid bits: out_valid=0, in_ready=1, S=0, Co=0, OVF=0, ZERO=1 (S=0).
REQ-031 SHALL, on reset asserted mid-operation, discard all in-flight tokens; none emerges after release.
REQ-032 SHALL accept operands on the first rising edge after rst_n deasserts.

Verification (WIDTH=16, GROUP=4, latency 4)
REQ-033 SHALL check: A=0x0000, B=0x0001, Cin=0, SUB=0, out_ready=1 -> 4 cycles later S=0x0001, Co=0, OVF=0, ZERO=0.
REQ-034 SHALL check: A=0xFFFF, B=0x0001, Cin=0 -> S=0x0000, Co=1, ZERO=1 (carry through all groups); A=0x7FFF, B=0x0001 -> S=0x8000, OVF=1.
REQ-035 SHALL check: SUB=1, A=0x0005, B=0x0007, Cin=1 -> S=0xFFFE, Co=0; A=0x8000, B=0x0001 -> S=0x7FFF, OVF=1.
REQ-036 SHALL check: back-to-back stream of 8 ops with out_ready toggled 1,0,0,1 pattern -> in_ready low exactly while stalled, 8 results in order, each matching a reference model.
REQ-037 SHALL check: rst_n pulled low for 1 cycle with 3 tokens in flight -> out_valid stays 0 afterwards until new ops accepted; next op emerges after 4 cycles.
REQ-038 SHALL check: random A,B,Cin,SUB 10000 ops, random out_ready, also WIDTH=32 GROUP=8 -> all results equal the model.
